// File: rtl/bus_access_ctrl.sv
// Per-master bus access sequencer: turns a core command into a req/grant,
// one-cycle address strobe, ready-wait bus transaction with a data-phase timeout.
module bus_access_ctrl #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter bit HOLD_BUS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_rw,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              m_req_n,
  input  logic              m_grnt_n,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_as_n,
  output logic              m_rw,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              m_rdy_n
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] cnt;
  logic        in_data_phase;
  logic        rdy_hit;
  logic        tmo_hit;

  // The counter already includes the ACCESS cycle, so it equals the number of
  // ready samples taken so far in the data phase.
  always_comb begin
    in_data_phase = (state == ACCESS) || (state == WAIT);
    rdy_hit       = in_data_phase && !m_rdy_n;
    tmo_hit       = in_data_phase && m_rdy_n && (cnt == TIMEOUT_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      m_req_n      <= 1'b1;
      m_as_n       <= 1'b1;
      m_rw         <= 1'b1;
      m_addr       <= '0;
      m_wr_data    <= '0;
      core_busy    <= 1'b0;
      core_done    <= 1'b0;
      core_err     <= 1'b0;
      core_rd_data <= '0;
    end else begin
      core_done <= 1'b0;
      core_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req) begin
            m_addr    <= core_addr;
            m_rw      <= core_rw;
            m_wr_data <= core_wr_data;
            m_req_n   <= 1'b0;
            core_busy <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          if (!m_grnt_n) begin
            m_as_n <= 1'b0;
            cnt    <= 16'd1;
            state  <= ACCESS;
          end
        end

        ACCESS, WAIT: begin
          m_as_n <= 1'b1;
          if (rdy_hit || tmo_hit) begin
            core_done    <= 1'b1;
            core_err     <= tmo_hit;
            core_rd_data <= (rdy_hit && m_rw) ? m_rd_data : '0;
            cnt          <= '0;
            // Back-to-back hold: keep the bus request and chain straight into REQ.
            if (HOLD_BUS && core_req) begin
              m_addr    <= core_addr;
              m_rw      <= core_rw;
              m_wr_data <= core_wr_data;
              state     <= REQ;
            end else begin
              m_req_n   <= 1'b1;
              m_addr    <= '0;
              m_wr_data <= '0;
              m_rw      <= 1'b1;
              core_busy <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            cnt   <= cnt + 16'd1;
            state <= WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_access_ctrl.sv
// Directed bench for bus_access_ctrl: one timeout-8 instance and one bus-hold
// instance sharing the same stimulus; outputs are sampled on the falling edge.
module tb_bus_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req;
  logic [29:0] core_addr;
  logic        core_rw;
  logic [31:0] core_wr_data;
  logic        m_grnt_n;
  logic [31:0] m_rd_data;
  logic        m_rdy_n;

  logic        core_busy, core_done, core_err, m_req_n, m_as_n, m_rw;
  logic [31:0] core_rd_data, m_wr_data;
  logic [29:0] m_addr;

  logic        h_busy, h_done, h_err, h_req_n, h_as_n, h_rw;
  logic [31:0] h_rd_data, h_wr_data;
  logic [29:0] h_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_access_ctrl #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(8), .HOLD_BUS(1'b0)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_addr(core_addr), .core_rw(core_rw), .core_wr_data(core_wr_data),
    .core_busy(core_busy), .core_done(core_done), .core_err(core_err), .core_rd_data(core_rd_data),
    .m_req_n(m_req_n), .m_grnt_n(m_grnt_n), .m_addr(m_addr), .m_as_n(m_as_n), .m_rw(m_rw),
    .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_rdy_n(m_rdy_n)
  );

  bus_access_ctrl #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(255), .HOLD_BUS(1'b1)) u_hold (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_addr(core_addr), .core_rw(core_rw), .core_wr_data(core_wr_data),
    .core_busy(h_busy), .core_done(h_done), .core_err(h_err), .core_rd_data(h_rd_data),
    .m_req_n(h_req_n), .m_grnt_n(m_grnt_n), .m_addr(h_addr), .m_as_n(h_as_n), .m_rw(h_rw),
    .m_wr_data(h_wr_data), .m_rd_data(m_rd_data), .m_rdy_n(m_rdy_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; core_req = 1'b0; core_addr = '0; core_rw = 1'b0; core_wr_data = '0;
    m_grnt_n = 1'b1; m_rdy_n = 1'b1; m_rd_data = '0;

    // Reset state
    tick(); tick();
    chk("rst m_req_n", 32'(m_req_n), 32'd1);
    chk("rst m_as_n", 32'(m_as_n), 32'd1);
    chk("rst m_rw", 32'(m_rw), 32'd1);
    chk("rst m_addr", 32'(m_addr), 32'd0);
    chk("rst m_wr_data", m_wr_data, 32'd0);
    chk("rst core_busy", 32'(core_busy), 32'd0);
    chk("rst core_done", 32'(core_done), 32'd0);
    chk("rst core_rd_data", core_rd_data, 32'd0);
    reset = 1'b1;
    tick();

    // Write: grant two cycles after request, ready one cycle after the strobe
    core_req = 1'b1; core_addr = 30'h1000_0000; core_rw = 1'b0; core_wr_data = 32'h1234;
    m_rd_data = 32'hDEAD_BEEF;
    tick();
    core_req = 1'b0;
    chk("wr m_req_n", 32'(m_req_n), 32'd0);
    chk("wr busy", 32'(core_busy), 32'd1);
    chk("wr m_addr", 32'(m_addr), 32'h1000_0000);
    chk("wr m_wr_data", m_wr_data, 32'h1234);
    chk("wr m_rw", 32'(m_rw), 32'd0);
    tick();
    chk("wr as_n before grant", 32'(m_as_n), 32'd1);
    m_grnt_n = 1'b0;
    tick();
    chk("wr as_n low", 32'(m_as_n), 32'd0);
    chk("wr strobe addr", 32'(m_addr), 32'h1000_0000);
    chk("wr strobe data", m_wr_data, 32'h1234);
    tick();
    chk("wr as_n one cycle", 32'(m_as_n), 32'd1);
    chk("wr no early done", 32'(core_done), 32'd0);
    m_rdy_n = 1'b0;
    tick();
    chk("wr done", 32'(core_done), 32'd1);
    chk("wr err", 32'(core_err), 32'd0);
    chk("wr rd_data zero", core_rd_data, 32'd0);
    chk("wr req_n released", 32'(m_req_n), 32'd1);
    chk("wr busy cleared", 32'(core_busy), 32'd0);
    m_rdy_n = 1'b1; m_grnt_n = 1'b1;
    tick();
    chk("wr done one cycle", 32'(core_done), 32'd0);

    // Read, immediate grant, ready sampled in the access cycle
    core_req = 1'b1; core_addr = 30'h3F00_0000; core_rw = 1'b1;
    m_grnt_n = 1'b0; m_rdy_n = 1'b0; m_rd_data = 32'h5678;
    tick();
    core_req = 1'b0;
    chk("rd req_n", 32'(m_req_n), 32'd0);
    chk("rd no done in REQ", 32'(core_done), 32'd0);
    tick();
    chk("rd as_n", 32'(m_as_n), 32'd0);
    tick();
    chk("rd done cycle3", 32'(core_done), 32'd1);
    chk("rd data", core_rd_data, 32'h5678);
    chk("rd err", 32'(core_err), 32'd0);
    m_grnt_n = 1'b1; m_rdy_n = 1'b1;
    tick();
    chk("rd done pulse", 32'(core_done), 32'd0);
    chk("rd req_n idle", 32'(m_req_n), 32'd1);

    // Timeout with TIMEOUT=8
    core_req = 1'b1; core_addr = 30'h0ABC; core_rw = 1'b1; m_grnt_n = 1'b0;
    m_rd_data = 32'hCAFE_F00D;
    tick();
    core_req = 1'b0;
    chk("to as_n high", 32'(m_as_n), 32'd1);
    tick();
    chk("to as_n low", 32'(m_as_n), 32'd0);
    for (int i = 3; i <= 9; i++) begin
      tick();
      chk($sformatf("to no done c%0d", i), 32'(core_done), 32'd0);
    end
    tick();
    chk("to done", 32'(core_done), 32'd1);
    chk("to err", 32'(core_err), 32'd1);
    chk("to rd_data", core_rd_data, 32'd0);
    chk("to req_n", 32'(m_req_n), 32'd1);
    chk("to busy", 32'(core_busy), 32'd0);
    m_grnt_n = 1'b1;
    tick();
    chk("to err pulse", 32'(core_err), 32'd0);
    m_rdy_n = 1'b0;
    tick();
    chk("late rdy no done a", 32'(core_done), 32'd0);
    tick();
    chk("late rdy no done b", 32'(core_done), 32'd0);
    chk("late rdy idle", 32'(core_busy), 32'd0);
    m_rdy_n = 1'b1;

    // Request pulsed while busy is ignored
    core_req = 1'b1; core_addr = 30'h111; core_rw = 1'b0; core_wr_data = 32'h111;
    tick();
    chk("bz busy", 32'(core_busy), 32'd1);
    core_addr = 30'h55; core_wr_data = 32'h55;
    tick();
    core_req = 1'b0;
    chk("bz m_addr kept", 32'(m_addr), 32'h111);
    chk("bz m_wr_data kept", m_wr_data, 32'h111);
    m_grnt_n = 1'b0;
    tick();
    chk("bz strobe addr", 32'(m_addr), 32'h111);
    chk("bz as_n", 32'(m_as_n), 32'd0);
    m_rdy_n = 1'b0;
    tick();
    chk("bz done", 32'(core_done), 32'd1);
    m_rdy_n = 1'b1; m_grnt_n = 1'b1;
    tick();
    chk("bz single done a", 32'(core_done), 32'd0);
    chk("bz idle", 32'(core_busy), 32'd0);
    chk("bz addr cleared", 32'(m_addr), 32'd0);
    tick();
    chk("bz single done b", 32'(core_done), 32'd0);

    // Reset asserted during WAIT
    core_req = 1'b1; core_addr = 30'h22; core_rw = 1'b1; m_grnt_n = 1'b0;
    tick();
    core_req = 1'b0;
    tick();
    tick();
    chk("rw in wait busy", 32'(core_busy), 32'd1);
    chk("rw in wait as_n", 32'(m_as_n), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rw async req_n", 32'(m_req_n), 32'd1);
    chk("rw async as_n", 32'(m_as_n), 32'd1);
    chk("rw async busy", 32'(core_busy), 32'd0);
    chk("rw async done", 32'(core_done), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rw no done after", 32'(core_done), 32'd0);
    core_req = 1'b1; core_addr = 30'h33; core_rw = 1'b0; core_wr_data = 32'hABCD;
    m_grnt_n = 1'b0; m_rdy_n = 1'b0;
    tick();
    core_req = 1'b0;
    chk("rw new wr data", m_wr_data, 32'hABCD);
    tick();
    chk("rw new as_n", 32'(m_as_n), 32'd0);
    tick();
    chk("rw new done", 32'(core_done), 32'd1);
    chk("rw new err", 32'(core_err), 32'd0);
    chk("rw new busy", 32'(core_busy), 32'd0);
    m_grnt_n = 1'b1; m_rdy_n = 1'b1;
    tick();

    // Bus hold: two back-to-back reads on the HOLD_BUS instance
    core_req = 1'b1; core_addr = 30'h40; core_rw = 1'b1; m_grnt_n = 1'b0;
    m_rd_data = 32'h1111;
    tick();
    core_addr = 30'h41;
    chk("hb req_n 1", 32'(h_req_n), 32'd0);
    tick();
    chk("hb as_n first", 32'(h_as_n), 32'd0);
    m_rdy_n = 1'b0;
    tick();
    chk("hb done 1", 32'(h_done), 32'd1);
    chk("hb data 1", h_rd_data, 32'h1111);
    chk("hb busy held", 32'(h_busy), 32'd1);
    chk("hb req_n held", 32'(h_req_n), 32'd0);
    chk("hb addr 2", 32'(h_addr), 32'h41);
    core_req = 1'b0; m_rdy_n = 1'b1; m_rd_data = 32'h2222;
    tick();
    chk("hb as_n second", 32'(h_as_n), 32'd0);
    chk("hb done pulse", 32'(h_done), 32'd0);
    chk("hb busy still", 32'(h_busy), 32'd1);
    chk("hb req_n still", 32'(h_req_n), 32'd0);
    m_rdy_n = 1'b0;
    tick();
    chk("hb done 2", 32'(h_done), 32'd1);
    chk("hb data 2", h_rd_data, 32'h2222);
    chk("hb busy end", 32'(h_busy), 32'd0);
    chk("hb req_n end", 32'(h_req_n), 32'd1);
    m_rdy_n = 1'b1; m_grnt_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_access_ctrl.md
Name: bus_access_ctrl

Overview:
- Per-master bus access sequencer. It converts a simple core-side command (request, address, read/write, write data) into the shared-bus master protocol: req_n/grnt_n arbitration handshake, a one-cycle as_n strobe, then a wait for rdy_n.
- It sits between a bus master (CPU instruction or data port, DMA) and one master slot (m0..m3) of bus_top.
- It adds a data-phase timeout that returns a bus error, plus an optional bus-hold for back-to-back accesses.

Parameters:
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles to wait for rdy_n (ACCESS + WAIT), range 1..65535.
- HOLD_BUS, 0, when 1, keep m_req_n asserted across back-to-back commands.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (0 = reset). One clock; asynchronous active-low reset.
- core_req  in  1  command valid; sampled only when core_busy=0.
- core_addr  in  ADDR_W  word address.
- core_rw  in  1  1=READ, 0=WRITE.
- core_wr_data  in  DATA_W  write data.
- core_busy  out  1  command accepted and not yet completed.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  one-cycle pulse with core_done on timeout.
- core_rd_data  out  DATA_W  read data; valid when core_done=1 (0 on write or error).
- m_req_n  out  1  bus request, active-low.
- m_grnt_n  in  1  bus grant from arbiter, active-low.
- m_addr  out  ADDR_W  bus address.
- m_as_n  out  1  address strobe, active-low.
- m_rw  out  1  bus read/write.
- m_wr_data  out  DATA_W  bus write data.
- m_rd_data  in  DATA_W  shared read data.
- m_rdy_n  in  1  shared ready, active-low; valid only while granted.

Behaviour:
- All outputs are registered.
- Reset values: m_req_n=1, m_as_n=1, m_rw=1, m_addr=0, m_wr_data=0, core_busy=0, core_done=0, core_err=0, core_rd_data=0, state IDLE, counter 0.
- Reset asserted mid-transaction returns to IDLE immediately (asynchronous) and drops m_req_n. The in-flight command is lost, with no done pulse.
- FSM states: IDLE, REQ, ACCESS, WAIT.
- IDLE: on core_req=1, latch addr/rw/wr_data onto m_addr/m_rw/m_wr_data. Next cycle: m_req_n=0, core_busy=1, state REQ.
- REQ: hold m_req_n=0. No timeout while waiting for grant. When m_grnt_n=0 is sampled, next cycle m_as_n=0 and state is ACCESS; the counter loads 1.
- ACCESS: m_as_n is low for exactly this one cycle. If m_rdy_n=0 is sampled, complete; otherwise go to WAIT.
- WAIT: m_as_n=1. The counter increments each cycle while m_rdy_n=1.
  - If m_rdy_n=0 is sampled, complete.
  - If counter==TIMEOUT and m_rdy_n=1, complete with error.
  - m_rdy_n is ignored in IDLE and REQ.
- Completion (next cycle):
  - core_done=1.
  - core_rd_data = m_rd_data if read, else 0.
  - core_err=1 if timeout; core_rd_data=0 on error.
  - core_busy=0, m_req_n=1, m_addr/m_wr_data=0, m_rw=1, state IDLE.
- HOLD_BUS=1 and core_req=1 in the completion-decision cycle:
  - latch the new command and keep m_req_n=0;
  - core_done pulses, core_busy stays 1;
  - state REQ (grant re-checked; ACCESS follows one cycle later if grant is still held).
- HOLD_BUS=0: core_req in the completion-decision cycle is ignored. It is accepted from IDLE the cycle after.
- core_req while busy (outside the HOLD_BUS case) is ignored. Inputs are not re-sampled, so command fields are stable from the latch.
- Late m_rdy_n after a timeout is ignored (state IDLE).
- Minimum latency is 3 cycles (req at cycle 0, grant sampled cycle 1, rdy sampled cycle 2, done in cycle 3).
- Counter width is 16 bits and cannot wrap, because it stops at TIMEOUT.

Test Plan:
- Write, TIMEOUT=255: core_req with addr 30'h1000_0000, WRITE, data 32'h1234; grnt_n low 2 cycles after m_req_n falls; rdy_n low 1 cycle after as_n -> m_as_n low exactly 1 cycle with m_addr=30'h1000_0000, m_wr_data=32'h1234, m_rw=0; core_done 1 cycle; core_rd_data=0; m_req_n high same cycle.
- Read with immediate grant and rdy_n in the ACCESS cycle: addr 30'h3F00_0000, m_rd_data=32'h5678 -> core_done in cycle 3 after core_req, core_rd_data=32'h5678, core_err=0.
- Timeout, TIMEOUT=8, rdy_n never asserted -> core_done=core_err=1 exactly 8 cycles after m_as_n falls, core_rd_data=0, m_req_n released; rdy_n low 2 cycles later produces no pulse.
- HOLD_BUS=1, two reads back-to-back (second core_req held at completion) -> m_req_n never deasserts between them, two core_done pulses, core_busy continuously 1, second as_n one cycle after the first done.
- Reset low during WAIT -> m_req_n=1, m_as_n=1, core_busy=0 immediately, no core_done; after release, a new write completes normally.
- core_req pulsed with addr 30'h0000_0055 while busy with another command -> ignored; m_addr stays at the first command's address; exactly one core_done.
